// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// mem_loader : framed, checksummed word-stream loader for instr/data BRAMs
// Rev 1.0
// ============================================================================
module mem_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int I_ADDR_WIDTH = 10,
  parameter int D_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic [I_ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0]   i_w_dat,
  output logic                    i_w_enb,
  output logic [D_ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0]   d_w_dat,
  output logic                    d_w_enb,
  output logic                    cpu_stall,
  output logic                    load_done,
  output logic                    load_err,
  output logic [1:0]              err_code
);

  // Two guard bits keep base + 4*N from wrapping for any base the stream can carry.
  localparam int c_EW = DATA_WIDTH + 2;
  localparam int c_AW = (I_ADDR_WIDTH > D_ADDR_WIDTH) ? I_ADDR_WIDTH : D_ADDR_WIDTH;

  localparam logic [c_EW-1:0] c_ONE   = {{(c_EW-1){1'b0}}, 1'b1};
  localparam logic [c_EW-1:0] c_I_LIM = c_ONE << I_ADDR_WIDTH;
  localparam logic [c_EW-1:0] c_D_LIM = c_ONE << D_ADDR_WIDTH;
  localparam logic [c_AW-1:0] c_WORD  = {{(c_AW-3){1'b0}}, 3'b100};

  localparam logic [2:0] c_ST_HDR  = 3'd0;
  localparam logic [2:0] c_ST_ADDR = 3'd1;
  localparam logic [2:0] c_ST_DATA = 3'd2;
  localparam logic [2:0] c_ST_CSUM = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;
  localparam logic [2:0] c_ST_ERR  = 3'd5;

  logic [2:0]              r_state;
  logic                    r_last;
  logic                    r_tgt;
  logic [15:0]             r_cnt;
  logic [c_AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0]   r_sum;
  logic [1:0]              r_err_code;
  logic                    r_i_enb;
  logic [I_ADDR_WIDTH-1:0] r_i_addr;
  logic [DATA_WIDTH-1:0]   r_i_dat;
  logic                    r_d_enb;
  logic [D_ADDR_WIDTH-1:0] r_d_addr;
  logic [DATA_WIDTH-1:0]   r_d_dat;

  logic            w_ready;
  logic            w_acc;
  logic [c_EW-1:0] w_end;
  logic [c_EW-1:0] w_lim;
  logic [2:0]      w_seg_next;

  assign w_ready    = (r_state == c_ST_HDR) || (r_state == c_ST_ADDR) ||
                      (r_state == c_ST_DATA) || (r_state == c_ST_CSUM);
  assign w_acc      = s_valid && w_ready;
  assign w_end      = {2'b00, s_data} + {{(c_EW-18){1'b0}}, r_cnt, 2'b00};
  assign w_lim      = r_tgt ? c_D_LIM : c_I_LIM;
  assign w_seg_next = r_last ? c_ST_CSUM : c_ST_HDR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_ST_HDR;
      r_last     <= 1'b0;
      r_tgt      <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_sum      <= '0;
      r_err_code <= 2'b00;
      r_i_enb    <= 1'b0;
      r_i_addr   <= '0;
      r_i_dat    <= '0;
      r_d_enb    <= 1'b0;
      r_d_addr   <= '0;
      r_d_dat    <= '0;
    end else begin
      r_i_enb <= 1'b0;
      r_d_enb <= 1'b0;
      if (w_acc) begin
        case (r_state)
          c_ST_HDR: begin
            r_last  <= s_data[31];
            r_tgt   <= s_data[30];
            r_cnt   <= s_data[15:0];
            r_state <= c_ST_ADDR;
          end
          c_ST_ADDR: begin
            r_addr <= s_data[c_AW-1:0];
            if (s_data[1:0] != 2'b00) begin
              r_err_code <= 2'b01;
              r_state    <= c_ST_ERR;
            end else if (w_end > w_lim) begin
              r_err_code <= 2'b10;
              r_state    <= c_ST_ERR;
            end else if (r_cnt == 16'd0) begin
              r_state <= w_seg_next;
            end else begin
              r_state <= c_ST_DATA;
            end
          end
          c_ST_DATA: begin
            r_sum  <= r_sum + s_data;
            r_addr <= r_addr + c_WORD;
            r_cnt  <= r_cnt - 16'd1;
            if (!r_tgt) begin
              r_i_enb  <= 1'b1;
              r_i_addr <= r_addr[I_ADDR_WIDTH-1:0];
              r_i_dat  <= s_data;
            end else begin
              r_d_enb  <= 1'b1;
              r_d_addr <= r_addr[D_ADDR_WIDTH-1:0];
              r_d_dat  <= s_data;
            end
            if (r_cnt == 16'd1) begin
              r_state <= w_seg_next;
            end
          end
          c_ST_CSUM: begin
            if (s_data == r_sum) begin
              r_state <= c_ST_DONE;
            end else begin
              r_err_code <= 2'b11;
              r_state    <= c_ST_ERR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign s_ready   = w_ready;
  assign i_w_addr  = r_i_addr;
  assign i_w_dat   = r_i_dat;
  assign i_w_enb   = r_i_enb;
  assign d_w_addr  = r_d_addr;
  assign d_w_dat   = r_d_dat;
  assign d_w_enb   = r_d_enb;
  assign cpu_stall = (r_state != c_ST_DONE);
  assign load_done = (r_state == c_ST_DONE);
  assign load_err  = (r_state == c_ST_ERR);
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// tb_mem_loader : randomized stream stimulus checked against a segment-level model
// Rev 1.0
// ============================================================================
module tb_mem_loader;

  localparam int DW  = 32;
  localparam int IAW = 10;
  localparam int DAW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           s_valid = 1'b0;
  logic [DW-1:0]  s_data = '0;
  logic           s_ready;
  logic [IAW-1:0] i_w_addr;
  logic [DW-1:0]  i_w_dat;
  logic           i_w_enb;
  logic [DAW-1:0] d_w_addr;
  logic [DW-1:0]  d_w_dat;
  logic           d_w_enb;
  logic           cpu_stall;
  logic           load_done;
  logic           load_err;
  logic [1:0]     err_code;

  always #5 clk = ~clk;

  mem_loader #(
    .DATA_WIDTH   (DW),
    .I_ADDR_WIDTH (IAW),
    .D_ADDR_WIDTH (DAW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .i_w_addr  (i_w_addr),
    .i_w_dat   (i_w_dat),
    .i_w_enb   (i_w_enb),
    .d_w_addr  (d_w_addr),
    .d_w_dat   (d_w_dat),
    .d_w_enb   (d_w_enb),
    .cpu_stall (cpu_stall),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  typedef struct {
    bit          tgt;
    int unsigned addr;
    logic [31:0] dat;
    int          tag;  // stream index (expected) or observation cycle (actual)
  } wr_t;

  wr_t         exp_q[$];
  wr_t         act_q[$];
  logic [31:0] stream[$];
  int          acc_cyc[$];
  int          cyc = 0;
  bit          done_seen = 1'b0;
  int          done_cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          exp_res;
  int          exp_code;
  int          exp_consumed;
  int          consumed;
  string       cur_test = "init";

  logic [31:0] g_sum;
  logic [31:0] g_word;
  logic [31:0] g_base;
  int          g_n;
  int          g_nseg;
  int          g_sel;
  bit          g_tgt;
  bit          g_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_test, tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (i_w_enb) act_q.push_back('{tgt: 1'b0, addr: 32'(i_w_addr), dat: i_w_dat, tag: cyc});
      if (d_w_enb) act_q.push_back('{tgt: 1'b1, addr: 32'(d_w_addr), dat: d_w_dat, tag: cyc});
      if (load_done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  // Walks the stream segment by segment and predicts writes and final status.
  task automatic model_stream();
    int          i = 0;
    int          n;
    bit          last;
    bit          tgt;
    bit          cut = 1'b0;
    logic [31:0] hdr;
    logic [31:0] sum = 32'd0;
    longint      b;
    longint      lim;
    exp_q.delete();
    exp_res  = 0;
    exp_code = 0;
    while (1'b1) begin
      if (i >= stream.size()) break;
      hdr  = stream[i]; i++;
      last = hdr[31];
      tgt  = hdr[30];
      n    = int'(hdr[15:0]);
      if (i >= stream.size()) break;
      b    = {32'd0, stream[i]}; i++;
      lim  = longint'(1) << (tgt ? DAW : IAW);
      if (b % 4 != 0) begin exp_res = 2; exp_code = 1; break; end
      if (b + 4 * longint'(n) > lim) begin exp_res = 2; exp_code = 2; break; end
      for (int k = 0; k < n; k++) begin
        if (i >= stream.size()) begin cut = 1'b1; break; end
        exp_q.push_back('{tgt: tgt, addr: 32'(b + 4 * k), dat: stream[i], tag: i});
        sum = sum + stream[i];
        i++;
      end
      if (cut) break;
      if (!last) continue;
      if (i >= stream.size()) break;
      if (stream[i] == sum) exp_res = 1;
      else begin exp_res = 2; exp_code = 3; end
      i++;
      break;
    end
    exp_consumed = i;
  endtask

  task automatic reset_dut();
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    act_q.delete();
    done_seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_stream(input int gap_pct);
    int idx = 0;
    int budget = 0;
    int c_now;
    bit acc;
    acc_cyc.delete();
    while (idx < stream.size() && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (!s_ready) begin
        s_valid = 1'b0;
        break;
      end
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? stream[idx] : $urandom();
      acc     = s_valid;
      c_now   = cyc;
      @(posedge clk);
      if (acc) begin
        acc_cyc.push_back(c_now);
        idx++;
      end
    end
    #1 s_valid = 1'b0;
    if (budget >= 3000) check_val("driver_budget", 64'(budget), 64'(0));
    consumed = idx;
  endtask

  task automatic run_and_check(input string name, input int gap_pct);
    int nw;
    cur_test = name;
    reset_dut();
    model_stream();
    run_stream(gap_pct);
    repeat (3) @(negedge clk);
    check_val("consumed", 64'(consumed), 64'(exp_consumed));
    check_val("wr_count", 64'(act_q.size()), 64'(exp_q.size()));
    nw = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      check_val("wr_tgt_addr", {31'd0, act_q[i].tgt, act_q[i].addr}, {31'd0, exp_q[i].tgt, exp_q[i].addr});
      check_val("wr_dat", 64'(act_q[i].dat), 64'(exp_q[i].dat));
      if (exp_q[i].tag < acc_cyc.size())
        check_val("wr_cycle", 64'(act_q[i].tag), 64'(acc_cyc[exp_q[i].tag] + 1));
    end
    check_val("load_done", 64'(load_done), 64'(exp_res == 1));
    check_val("load_err", 64'(load_err), 64'(exp_res == 2));
    check_val("err_code", 64'(err_code), 64'(exp_code));
    check_val("cpu_stall", 64'(cpu_stall), 64'(exp_res != 1));
    check_val("s_ready", 64'(s_ready), 64'(exp_res == 0));
    if (exp_res == 1 && consumed > 0)
      check_val("done_latency", 64'(done_cyc - acc_cyc[consumed-1]), 64'(1));
  endtask

  task automatic build_two_seg(input bit bad_csum);
    stream.delete();
    g_sum = 32'd0;
    stream.push_back(32'h0000_0008);
    stream.push_back(32'h0000_0000);
    for (int k = 0; k < 8; k++) begin
      g_word = $urandom();
      stream.push_back(g_word);
      g_sum = g_sum + g_word;
    end
    stream.push_back(32'hC000_0003);
    stream.push_back(32'h0000_0000);
    for (int k = 1; k <= 3; k++) begin
      stream.push_back(32'(k));
      g_sum = g_sum + 32'(k);
    end
    stream.push_back(bad_csum ? g_sum + 32'd1 : g_sum);
  endtask

  task automatic build_random();
    stream.delete();
    g_sum  = 32'd0;
    g_nseg = $urandom_range(1, 3);
    for (int s = 0; s < g_nseg; s++) begin
      g_tgt  = 1'($urandom_range(1));
      g_last = (s == g_nseg - 1);
      g_n    = $urandom_range(0, 6);
      g_base = 32'(4 * $urandom_range(0, 256 - g_n));
      g_sel  = $urandom_range(15);
      if (g_sel == 0) g_base = g_base | 32'($urandom_range(1, 3));
      if (g_sel == 1) g_base = 32'(1028 - 4 * g_n);
      stream.push_back({g_last, g_tgt, 14'($urandom()), 16'(g_n)});
      stream.push_back(g_base);
      for (int k = 0; k < g_n; k++) begin
        g_word = $urandom();
        stream.push_back(g_word);
        g_sum = g_sum + g_word;
      end
    end
    stream.push_back(($urandom_range(7) == 0) ? g_sum + 32'd1 : g_sum);
  endtask

  initial begin
    cur_test = "reset";
    reset_dut();
    check_val("s_ready", 64'(s_ready), 64'(1));
    check_val("cpu_stall", 64'(cpu_stall), 64'(1));
    check_val("load_done", 64'(load_done), 64'(0));
    check_val("load_err", 64'(load_err), 64'(0));
    check_val("err_code", 64'(err_code), 64'(0));
    check_val("enables", {62'd0, i_w_enb, d_w_enb}, 64'(0));

    build_two_seg(1'b0);
    run_and_check("two_seg", 0);
    build_two_seg(1'b0);
    run_and_check("two_seg_gaps", 40);
    build_two_seg(1'b1);
    run_and_check("bad_csum", 20);

    stream = '{32'h8000_0001, 32'h0000_0002, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    run_and_check("misaligned", 0);
    stream = '{32'h8000_0002, 32'h0000_03FC, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    run_and_check("out_of_range", 0);
    stream = '{32'h8000_0001, 32'h0000_03FC, 32'h1234_5678, 32'h1234_5678};
    run_and_check("top_word", 30);
    stream = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    run_and_check("empty_seg", 30);
    stream = '{32'hC000_0002, 32'h0000_0100, 32'hAAAA_0001, 32'hAAAA_0002, 32'h5554_0003};
    run_and_check("data_only", 50);

    cur_test = "async_rst";
    reset_dut();
    stream = '{32'h0000_0008, 32'h0000_0040, 32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002};
    run_stream(0);
    #1;
    check_val("pulse_before_rst", 64'(i_w_enb), 64'(1));
    rst = 1'b0;
    #1;
    check_val("i_w_enb", 64'(i_w_enb), 64'(0));
    check_val("i_w_addr", 64'(i_w_addr), 64'(0));
    check_val("i_w_dat", 64'(i_w_dat), 64'(0));
    check_val("s_ready", 64'(s_ready), 64'(1));
    check_val("cpu_stall", 64'(cpu_stall), 64'(1));
    check_val("wr_count", 64'(act_q.size()), 64'(2));
    build_two_seg(1'b0);
    run_and_check("reload_after_rst", 25);

    for (int r = 0; r < 14; r++) begin
      build_random();
      run_and_check($sformatf("rand%0d", r), $urandom_range(0, 60));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
